sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one SRAM-like bus (req/addr_ok/data_ok, in-order responses) between the instruction-fetch master and the data-memory master of the pipeline.
- Chooses which request reaches the bus and keeps that choice until the bus accepts it.
- Records where each outstanding transaction came from, so each data_ok goes back to the right master.
- Sits between the fetch/decode handshake (inst_rdata/inst_data_ok) and the memory-stage data port on one side, and the bus bridge on the other.

Parameters:
- DEPTH, 4, maximum outstanding transactions tracked; power of two, 2..16.
- PTR_W, $clog2(DEPTH), width of the order-FIFO pointers; derived, not overridden.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous assert, active-low
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch response data
- data_req  in  1  data request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid (read data or write acknowledge)
- data_rdata  out  32  read data
- bus_req  out  1  request to the bus
- bus_wr  out  1  write flag
- bus_size  out  2  access size
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  bus accepted the request
- bus_data_ok  in  1  bus response valid (in order)
- bus_rdata  in  32  bus response data
- err_o  out  1  sticky protocol error
- perfcnt_inst_wait  out  32  cycles with inst_req high and inst_addr_ok low

Behaviour:
- Reset (resetn low, asynchronous):
  - grant state is IDLE; FIFO is empty (pointers 0, count 0).
  - err_o = 0; perfcnt_inst_wait = 0.
  - All request outputs are combinational from state and inputs; with no requests they are 0.
- Grant FSM states:
  - IDLE: no grant is held. Selection is data if data_req, else inst if inst_req. Data has fixed priority.
  - HOLD_I / HOLD_D: a request was presented without bus_addr_ok. The same master stays selected regardless of the other master's req. State returns to IDLE in the cycle bus_addr_ok is seen.
  - If the held master drops its req, state returns to IDLE next cycle and no transfer is counted.
- Transitions:
  - IDLE → HOLD_x when bus_req && !bus_addr_ok && selected = x.
  - HOLD_x → IDLE on bus_addr_ok, or when x_req is low.
- Bus side:
  - bus_req = selected_req && !full.
  - bus_wr, bus_size, bus_addr and bus_wdata are muxed from the selected master.
  - Fetch presents wr = 0, size = 2, wdata = 0.
- Acceptance:
  - x_addr_ok = bus_addr_ok && bus_req && selected = x.
  - The unselected master never sees addr_ok.
- Order FIFO:
  - On acceptance, push the source bit (1 = data).
  - On bus_data_ok with the FIFO not empty, pop the head.
  - inst_data_ok = bus_data_ok && !empty && head == 0; data_data_ok likewise for head == 1.
  - bus_rdata fans out to both rdata ports.
  - Push and pop in the same cycle leaves count unchanged; pointers wrap modulo DEPTH.
- Full handling:
  - When count == DEPTH, bus_req = 0, even if bus_data_ok arrives that cycle. There is no combinational data_ok→req path.
  - The grant FSM holds its state while full.
- Response with empty FIFO:
  - bus_data_ok while empty: no data_ok to either master, err_o sets and stays set until reset, count stays 0.
- Latency:
  - Zero-cycle pass-through in both directions; the FSM and FIFO add only state, no register stages.
- perfcnt_inst_wait: increments by 1 each cycle inst_req && !inst_addr_ok; wraps at 2^32.
- Reset mid-operation: all outstanding tracking is discarded. Responses arriving after reset are treated as the empty case and set err_o; the bus bridge must be reset together with this block.

Decomposition:
- Shared package/header holds:
  - source encoding SRC_INST = 0, SRC_DATA = 1;
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state constants GNT_IDLE, GNT_HOLD_I, GNT_HOLD_D.
- One sub-module is natural: order_fifo, parameterised width 1 and depth DEPTH, with push/pop/full/empty/head. The arbiter instantiates it once.

Test Plan:
- Fetch alone: inst_req = 1, addr 0xBFC00000, bus_addr_ok = 1 at cycle 0, bus_data_ok with rdata 0x3C1D8000 at cycle 2 → inst_addr_ok at cycle 0, inst_data_ok and inst_rdata 0x3C1D8000 at cycle 2; err_o = 0.
- Priority and hold:
  - cycle 0: inst_req = 1, bus_addr_ok = 0.
  - cycle 1: data_req = 1 rises; inst is still held, bus_addr = inst_addr.
  - cycle 2: bus_addr_ok = 1 → inst accepted.
  - cycle 3: data is granted.
  - FIFO order afterwards is {0, 1}.
- Interleaved responses: accept inst, data, inst; return three bus_data_ok with 0x11, 0x22, 0x33 → inst gets 0x11, data gets 0x22, inst gets 0x33, in that order.
- Full: DEPTH = 4, four accepts with no response → bus_req stays 0 with both masters requesting. One bus_data_ok → bus_req rises the next cycle.
- Protocol error and reset: bus_data_ok with the FIFO empty → no master data_ok, err_o = 1 and stays 1. Assert resetn = 0 asynchronously mid-cycle → err_o, count and perfcnt_inst_wait read 0 immediately.
- Perf counter: inst_req held for 5 cycles, with data_req also high for the first 3 cycles and bus_addr_ok = 1 throughout → perfcnt_inst_wait = 3.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: transaction source tags, access
// sizes and grant-FSM states.
package sram_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        GNT_IDLE   = 2'd0,
        GNT_HOLD_I = 2'd1,
        GNT_HOLD_D = 2'd2
    } gnt_state_t;

    // Hold state that keeps the given source selected until the bus accepts it.
    function automatic gnt_state_t hold_state(input logic src);
        gnt_state_t st;
        if (src == SRC_DATA) begin
            st = GNT_HOLD_D;
        end else begin
            st = GNT_HOLD_I;
        end
        return st;
    endfunction

endpackage

// File: rtl/sram_arbiter_order_fifo.sv
// Small FIFO remembering which master issued each outstanding bus transaction,
// so in-order bus responses can be steered back to their owner.
module sram_arbiter_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == (PTR_W+1)'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the fetch and data masters onto one SRAM-like bus with fixed data
// priority, grant hold until acceptance, and in-order response routing.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        err_o,
    output logic [31:0] perfcnt_inst_wait
);

    gnt_state_t state_r;
    logic       sel_src_s;
    logic       sel_req_s;
    logic       accept_s;
    logic       pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       fifo_head_s;
    logic       err_r;
    logic [31:0] perf_r;

    // Selection: a held grant wins, otherwise data has fixed priority over fetch.
    always_comb begin
        sel_src_s = SRC_INST;
        case (state_r)
            GNT_IDLE:   sel_src_s = data_req ? SRC_DATA : SRC_INST;
            GNT_HOLD_I: sel_src_s = SRC_INST;
            GNT_HOLD_D: sel_src_s = SRC_DATA;
            default:    sel_src_s = SRC_INST;
        endcase
    end

    // Bus request and attribute mux; fetch always reads a full word.
    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = SZ_WORD;
        bus_addr  = inst_addr;
        bus_wdata = 32'h0000_0000;
        sel_req_s = inst_req;
        if (sel_src_s == SRC_DATA) begin
            bus_wr    = data_wr;
            bus_size  = data_size;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
            sel_req_s = data_req;
        end else begin
            bus_wr    = 1'b0;
            bus_size  = SZ_WORD;
            bus_addr  = inst_addr;
            bus_wdata = 32'h0000_0000;
            sel_req_s = inst_req;
        end
    end

    // Full FIFO blocks requests outright; a same-cycle response does not
    // reopen the request path, keeping data_ok off the req timing path.
    assign bus_req      = sel_req_s && !fifo_full_s;
    assign accept_s     = bus_req && bus_addr_ok;
    assign inst_addr_ok = accept_s && (sel_src_s == SRC_INST);
    assign data_addr_ok = accept_s && (sel_src_s == SRC_DATA);

    assign pop_s        = bus_data_ok && !fifo_empty_s;
    assign inst_data_ok = pop_s && (fifo_head_s == SRC_INST);
    assign data_data_ok = pop_s && (fifo_head_s == SRC_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign err_o             = err_r;
    assign perfcnt_inst_wait = perf_r;

    sram_arbiter_order_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept_s),
        .pop    (pop_s),
        .din    (sel_src_s),
        .head   (fifo_head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Grant FSM: hold the selected master until accepted or it withdraws.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= GNT_IDLE;
        end else begin
            case (state_r)
                GNT_IDLE: begin
                    if (bus_req && !bus_addr_ok) begin
                        state_r <= hold_state(sel_src_s);
                    end else begin
                        state_r <= GNT_IDLE;
                    end
                end
                GNT_HOLD_I: begin
                    if (fifo_full_s) begin
                        state_r <= GNT_HOLD_I;
                    end else if (bus_addr_ok || !inst_req) begin
                        state_r <= GNT_IDLE;
                    end else begin
                        state_r <= GNT_HOLD_I;
                    end
                end
                GNT_HOLD_D: begin
                    if (fifo_full_s) begin
                        state_r <= GNT_HOLD_D;
                    end else if (bus_addr_ok || !data_req) begin
                        state_r <= GNT_IDLE;
                    end else begin
                        state_r <= GNT_HOLD_D;
                    end
                end
                default: state_r <= GNT_IDLE;
            endcase
        end
    end

    // Sticky error for a response with nothing outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if (bus_data_ok && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Fetch stall counter, wrapping at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_r <= 32'h0000_0000;
        end else if (inst_req && !inst_addr_ok) begin
            perf_r <= perf_r + 32'h0000_0001;
        end else begin
            perf_r <= perf_r;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario-based and randomized bench for sram_arbiter; expectations come from
// directed constants and a queue-based model of the arbitration rules.
module tb_sram_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        err_o;
    logic [31:0] perfcnt_inst_wait;

    int checks = 0;
    int failures = 0;

    sram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_data_ok      (inst_data_ok),
        .inst_rdata        (inst_rdata),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .bus_req           (bus_req),
        .bus_wr            (bus_wr),
        .bus_size          (bus_size),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_addr_ok       (bus_addr_ok),
        .bus_data_ok       (bus_data_ok),
        .bus_rdata         (bus_rdata),
        .err_o             (err_o),
        .perfcnt_inst_wait (perfcnt_inst_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL reset_req: bus_req=%b iok=%b dok=%b expected 0 0 0", bus_req, inst_addr_ok, data_addr_ok);
        end
        checks++;
        if (err_o !== 1'b0 || perfcnt_inst_wait !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: err=%b perf=%0d expected 0 0", err_o, perfcnt_inst_wait);
        end
    endtask

    task automatic test_fetch_alone();
        do_reset();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'hBFC0_0000 || bus_wr !== 1'b0 || bus_size !== 2'd2 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_bus: req=%b addr=%h wr=%b size=%0d wdata=%h expected 1 bfc00000 0 2 0", bus_req, bus_addr, bus_wr, bus_size, bus_wdata);
        end
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL fetch_addr_ok: iok=%b dok=%b expected 1 0", inst_addr_ok, data_addr_ok);
        end
        @(negedge clk);
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h3C1D_8000;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h3C1D_8000) begin
            failures++;
            $display("FAIL fetch_resp: idok=%b ddok=%b rdata=%h expected 1 0 3c1d8000", inst_data_ok, data_data_ok, inst_rdata);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0 || perfcnt_inst_wait !== 32'd0) begin
            failures++;
            $display("FAIL fetch_err: err=%b perf=%0d expected 0 0", err_o, perfcnt_inst_wait);
        end
    endtask

    task automatic test_priority_hold();
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1000 || inst_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL hold_c0: req=%b addr=%h iok=%b expected 1 00001000 0", bus_req, bus_addr, inst_addr_ok);
        end
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h8000_0040; data_wr = 1'b1; data_size = 2'd1; data_wdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (bus_addr !== 32'h0000_1000 || bus_wr !== 1'b0 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
            failures++;
            $display("FAIL hold_c1: addr=%h wr=%b dok=%b iok=%b expected 00001000 0 0 0", bus_addr, bus_wr, data_addr_ok, inst_addr_ok);
        end
        @(negedge clk);
        bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || bus_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL hold_c2: iok=%b dok=%b addr=%h expected 1 0 00001000", inst_addr_ok, data_addr_ok, bus_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || bus_addr !== 32'h8000_0040 || bus_wr !== 1'b1 || bus_size !== 2'd1 || bus_wdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL hold_c3: dok=%b iok=%b addr=%h wr=%b size=%0d wdata=%h expected 1 0 80000040 1 1 cafef00d", data_addr_ok, inst_addr_ok, bus_addr, bus_wr, bus_size, bus_wdata);
        end
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hA;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL hold_order0: idok=%b ddok=%b expected 1 0", inst_data_ok, data_data_ok);
        end
        @(negedge clk);
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b1) begin
            failures++;
            $display("FAIL hold_order1: idok=%b ddok=%b expected 0 1", inst_data_ok, data_data_ok);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        checks++;
        if (perfcnt_inst_wait !== 32'd3 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_perf: perf=%0d err=%b expected 3 0", perfcnt_inst_wait, err_o);
        end
    endtask

    task automatic test_interleaved();
        logic        src [3];
        logic [31:0] rd  [3];
        src[0] = 1'b0; src[1] = 1'b1; src[2] = 1'b0;
        rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
        do_reset();
        bus_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inst_req = ~src[i]; data_req = src[i];
            #1;
            checks++;
            if (inst_addr_ok !== ~src[i] || data_addr_ok !== src[i]) begin
                failures++;
                $display("FAIL inter_acc%0d: iok=%b dok=%b expected %b %b", i, inst_addr_ok, data_addr_ok, ~src[i], src[i]);
            end
            @(negedge clk);
        end
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_data_ok = 1'b1; bus_rdata = rd[i];
            #1;
            checks++;
            if (inst_data_ok !== ~src[i] || data_data_ok !== src[i] || (src[i] ? data_rdata : inst_rdata) !== rd[i]) begin
                failures++;
                $display("FAIL inter_resp%0d: idok=%b ddok=%b irdata=%h drdata=%h expected %b %b %h", i, inst_data_ok, data_data_ok, inst_rdata, data_rdata, ~src[i], src[i], rd[i]);
            end
            @(negedge clk);
        end
        bus_data_ok = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
                failures++;
                $display("FAIL full_fill%0d: dok=%b iok=%b expected 1 0", i, data_addr_ok, inst_addr_ok);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus_req !== 1'b0 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
                failures++;
                $display("FAIL full_block%0d: req=%b dok=%b iok=%b expected 0 0 0", i, bus_req, data_addr_ok, inst_addr_ok);
            end
            @(negedge clk);
        end
        bus_data_ok = 1'b1;
        #1;
        checks++;
        if (bus_req !== 1'b0 || data_data_ok !== 1'b1) begin
            failures++;
            $display("FAIL full_pop: req=%b ddok=%b expected 0 1", bus_req, data_data_ok);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b1 || data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL full_reopen: req=%b dok=%b expected 1 1", bus_req, data_addr_ok);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_perfcnt();
        do_reset();
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_req = (i < 3);
            bus_data_ok = (i > 0);
            @(negedge clk);
        end
        clear_inputs();
        #1;
        checks++;
        if (perfcnt_inst_wait !== 32'd3) begin
            failures++;
            $display("FAIL perfcnt: got %0d expected 3", perfcnt_inst_wait);
        end
    endtask

    task automatic test_random();
        int          holder;
        logic        q[$];
        logic        exp_err;
        logic [31:0] exp_perf;
        logic        is_full, sel_data, sel_req, e_req, acc, e_idok, e_ddok;
        do_reset();
        holder = 0; exp_err = 1'b0; exp_perf = 32'h0;
        for (int c = 0; c < 600; c++) begin
            inst_req    = ($urandom_range(0, 99) < 60);
            inst_addr   = $urandom;
            data_req    = ($urandom_range(0, 99) < 45);
            data_wr     = $urandom_range(0, 1);
            data_size   = 2'($urandom_range(0, 2));
            data_addr   = $urandom;
            data_wdata  = $urandom;
            bus_addr_ok = ($urandom_range(0, 99) < 50);
            bus_data_ok = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
            bus_rdata   = $urandom;
            #1;
            checks++;
            if (err_o !== exp_err || perfcnt_inst_wait !== exp_perf) begin
                failures++;
                $display("FAIL rnd_regs c%0d: err=%b perf=%0d expected %b %0d", c, err_o, perfcnt_inst_wait, exp_err, exp_perf);
            end
            is_full  = (q.size() == DEPTH);
            sel_data = (holder == 1) ? 1'b0 : (holder == 2) ? 1'b1 : data_req;
            sel_req  = sel_data ? data_req : inst_req;
            e_req    = sel_req && !is_full;
            acc      = e_req && bus_addr_ok;
            e_idok   = bus_data_ok && (q.size() > 0) && (q[0] == 1'b0);
            e_ddok   = bus_data_ok && (q.size() > 0) && (q[0] == 1'b1);
            checks++;
            if (bus_req !== e_req || inst_addr_ok !== (acc && !sel_data) || data_addr_ok !== (acc && sel_data)) begin
                failures++;
                $display("FAIL rnd_req c%0d: req=%b iok=%b dok=%b expected %b %b %b", c, bus_req, inst_addr_ok, data_addr_ok, e_req, acc && !sel_data, acc && sel_data);
            end
            checks++;
            if (bus_addr !== (sel_data ? data_addr : inst_addr) || bus_wr !== (sel_data ? data_wr : 1'b0) ||
                bus_size !== (sel_data ? data_size : 2'd2) || bus_wdata !== (sel_data ? data_wdata : 32'h0)) begin
                failures++;
                $display("FAIL rnd_mux c%0d: addr=%h wr=%b size=%0d wdata=%h sel_data=%b", c, bus_addr, bus_wr, bus_size, bus_wdata, sel_data);
            end
            checks++;
            if (inst_data_ok !== e_idok || data_data_ok !== e_ddok || inst_rdata !== bus_rdata || data_rdata !== bus_rdata) begin
                failures++;
                $display("FAIL rnd_resp c%0d: idok=%b ddok=%b expected %b %b", c, inst_data_ok, data_data_ok, e_idok, e_ddok);
            end
            if (bus_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else exp_err = 1'b1;
            end
            if (acc) q.push_back(sel_data);
            if (inst_req && !(acc && !sel_data)) exp_perf = exp_perf + 32'd1;
            if (!is_full) begin
                if (holder == 0) begin
                    if (e_req && !bus_addr_ok) holder = sel_data ? 2 : 1;
                end else if (bus_addr_ok || !sel_req) begin
                    holder = 0;
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_error_reset();
        do_reset();
        bus_data_ok = 1'b1; bus_rdata = 32'h5555_AAAA;
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL err_nodok: idok=%b ddok=%b expected 0 0", inst_data_ok, data_data_ok);
        end
        @(negedge clk);
        bus_data_ok = 1'b0; inst_req = 1'b1;
        repeat (3) @(negedge clk);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1 || perfcnt_inst_wait !== 32'd3) begin
            failures++;
            $display("FAIL err_sticky: err=%b perf=%0d expected 1 3", err_o, perfcnt_inst_wait);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0 || perfcnt_inst_wait !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: err=%b perf=%0d expected 0 0", err_o, perfcnt_inst_wait);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus_data_ok = 1'b1;
        #1;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: idok=%b ddok=%b expected 0 0", inst_data_ok, data_data_ok);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_err: err=%b expected 1", err_o);
        end
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_fetch_alone();
        test_priority_hold();
        test_interleaved();
        test_full();
        test_perfcnt();
        test_random();
        test_error_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
